// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline types: ALU op codes, forward selects, ID/EX register layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [REGW-1:0]   rs1;
        logic [REGW-1:0]   rs2;
        logic [REGW-1:0]   rd;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [3:0]        alu_control;
        logic              alu_src_a;
        logic              alu_src_b;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } id_ex_t;

    // rd = 0 on a bubble keeps it invisible to both forwarding and load-use checks.
    function automatic id_ex_t id_ex_bubble();
        id_ex_t b;
        b             = '0;
        b.alu_control = ALU_ADD;
        return b;
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Operand forward select for one source index; EX/MEM beats MEM/WB, x0 never forwards.
// Latency: combinational.
// Backpressure: none.
module forward_unit
    import rv32i_pkg::*;
(
    input  logic [4:0] i_src_idx,
    input  logic       i_mem_reg_write,
    input  logic [4:0] i_mem_rd,
    input  logic       i_wb_reg_write,
    input  logic [4:0] i_wb_rd,
    output logic [1:0] o_sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = i_mem_reg_write && (i_mem_rd != 5'd0) && (i_mem_rd == i_src_idx);
    assign w_wb_hit  = i_wb_reg_write  && (i_wb_rd  != 5'd0) && (i_wb_rd  == i_src_idx);

    always_comb begin
        o_sel = FWD_REG;
        if (w_mem_hit) begin
            o_sel = FWD_MEM;
        end else if (w_wb_hit) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with operand forwarding and load-use stall generation feeding the ALU.
// Latency: 1 cycle ID->EX; SrcA/SrcB/ex_store_data combinational from EX regs and MEM/WB.
// Backpressure: hold freezes EX; load-use raises stall_id and injects one bubble; flush wins.
module ex_operand_stage
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,

    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rd1,
    input  logic [31:0] id_rd2,
    input  logic [31:0] id_imm,
    input  logic [3:0]  id_alu_control,
    input  logic        id_alu_src_a,
    input  logic        id_alu_src_b,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,

    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_result,

    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_result,

    input  logic        hold,
    input  logic        flush,

    output logic [31:0] SrcA,
    output logic [31:0] SrcB,
    output logic [3:0]  ALUControl,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [4:0]  ex_rd,
    output logic [31:0] ex_store_data,
    output logic        stall_id
);

    id_ex_t      r_ex;
    id_ex_t      w_ex_next;
    id_ex_t      w_id_load;
    logic        w_stall;
    logic        w_src_match;
    logic [1:0]  w_sel_a;
    logic [1:0]  w_sel_b;
    logic [31:0] w_fwd_a;
    logic [31:0] w_fwd_b;

    always_comb begin
        w_id_load             = '0;
        w_id_load.valid       = id_valid;
        w_id_load.pc          = id_pc;
        w_id_load.rs1         = id_rs1;
        w_id_load.rs2         = id_rs2;
        w_id_load.rd          = id_rd;
        w_id_load.rd1         = id_rd1;
        w_id_load.rd2         = id_rd2;
        w_id_load.imm         = id_imm;
        w_id_load.alu_control = id_alu_control;
        w_id_load.alu_src_a   = id_alu_src_a;
        w_id_load.alu_src_b   = id_alu_src_b;
        w_id_load.reg_write   = id_reg_write;
        w_id_load.mem_read    = id_mem_read;
        w_id_load.mem_write   = id_mem_write;
    end

    // Conservative: rs2 is compared even when the consumer only reads rs1.
    assign w_src_match = (id_rs1 == r_ex.rd) || (id_rs2 == r_ex.rd);
    assign w_stall     = r_ex.valid && r_ex.mem_read && (r_ex.rd != 5'd0)
                         && id_valid && w_src_match && !flush;
    assign stall_id    = w_stall;

    always_comb begin
        w_ex_next = w_id_load;
        if (flush) begin
            w_ex_next = id_ex_bubble();
        end else if (hold) begin
            w_ex_next = r_ex;
        end else if (w_stall) begin
            w_ex_next = id_ex_bubble();
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex <= id_ex_bubble();
        end else begin
            r_ex <= w_ex_next;
        end
    end

    forward_unit u_fwd_a (
        .i_src_idx       (r_ex.rs1),
        .i_mem_reg_write (mem_reg_write),
        .i_mem_rd        (mem_rd),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_rd         (wb_rd),
        .o_sel           (w_sel_a)
    );

    forward_unit u_fwd_b (
        .i_src_idx       (r_ex.rs2),
        .i_mem_reg_write (mem_reg_write),
        .i_mem_rd        (mem_rd),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_rd         (wb_rd),
        .o_sel           (w_sel_b)
    );

    always_comb begin
        w_fwd_a = r_ex.rd1;
        case (w_sel_a)
            FWD_MEM: w_fwd_a = mem_result;
            FWD_WB:  w_fwd_a = wb_result;
            default: w_fwd_a = r_ex.rd1;
        endcase
    end

    always_comb begin
        w_fwd_b = r_ex.rd2;
        case (w_sel_b)
            FWD_MEM: w_fwd_b = mem_result;
            FWD_WB:  w_fwd_b = wb_result;
            default: w_fwd_b = r_ex.rd2;
        endcase
    end

    // Store data always takes the forwarded rs2, even when SrcB is the immediate.
    assign SrcA          = r_ex.alu_src_a ? r_ex.pc  : w_fwd_a;
    assign SrcB          = r_ex.alu_src_b ? r_ex.imm : w_fwd_b;
    assign ex_store_data = w_fwd_b;

    assign ALUControl    = r_ex.alu_control;
    assign ex_valid      = r_ex.valid;
    assign ex_reg_write  = r_ex.reg_write;
    assign ex_mem_read   = r_ex.mem_read;
    assign ex_mem_write  = r_ex.mem_write;
    assign ex_rd         = r_ex.rd;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: vector table plus load-use, hold, flush and reset sequences.
module tb_ex_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rd1, id_rd2, id_imm;
    logic [3:0]  id_alu_control;
    logic        id_alu_src_a, id_alu_src_b;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        hold, flush;
    logic [31:0] SrcA, SrcB, ex_store_data;
    logic [3:0]  ALUControl;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [4:0]  ex_rd;
    logic        stall_id;

    int checks = 0;
    int errors = 0;

    ex_operand_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .id_rd1         (id_rd1),
        .id_rd2         (id_rd2),
        .id_imm         (id_imm),
        .id_alu_control (id_alu_control),
        .id_alu_src_a   (id_alu_src_a),
        .id_alu_src_b   (id_alu_src_b),
        .id_reg_write   (id_reg_write),
        .id_mem_read    (id_mem_read),
        .id_mem_write   (id_mem_write),
        .mem_reg_write  (mem_reg_write),
        .mem_rd         (mem_rd),
        .mem_result     (mem_result),
        .wb_reg_write   (wb_reg_write),
        .wb_rd          (wb_rd),
        .wb_result      (wb_result),
        .hold           (hold),
        .flush          (flush),
        .SrcA           (SrcA),
        .SrcB           (SrcB),
        .ALUControl     (ALUControl),
        .ex_valid       (ex_valid),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_rd          (ex_rd),
        .ex_store_data  (ex_store_data),
        .stall_id       (stall_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rd1, rd2, imm;
        logic [3:0]  alu;
        logic        sa, sb, rw, mr, mw;
        logic        mrw;
        logic [4:0]  mrd;
        logic [31:0] mres;
        logic        wrw;
        logic [4:0]  wrd;
        logic [31:0] wres;
        logic        hold, flush;
        logic [31:0] e_srca, e_srcb, e_store;
        logic [3:0]  e_alu;
        logic        e_valid;
        logic [4:0]  e_rd;
        logic        e_rw, e_mr, e_mw, e_stall;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic set_id(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                          input logic sb, input logic rw, input logic mr);
        id_valid       = iv;
        id_pc          = 32'h0;
        id_rs1         = rs1;
        id_rs2         = rs2;
        id_rd          = rd;
        id_rd1         = rd1;
        id_rd2         = rd2;
        id_imm         = 32'h0;
        id_alu_control = 4'd0;
        id_alu_src_a   = 1'b0;
        id_alu_src_b   = sb;
        id_reg_write   = rw;
        id_mem_read    = mr;
        id_mem_write   = 1'b0;
    endtask

    task automatic set_fwd(input logic mrw, input logic [4:0] mrd, input logic [31:0] mres,
                           input logic wrw, input logic [4:0] wrd, input logic [31:0] wres);
        mem_reg_write = mrw;
        mem_rd        = mrd;
        mem_result    = mres;
        wb_reg_write  = wrw;
        wb_rd         = wrd;
        wb_result     = wres;
    endtask

    task automatic apply(input vec_t v);
        id_valid       = v.iv;
        id_pc          = v.pc;
        id_rs1         = v.rs1;
        id_rs2         = v.rs2;
        id_rd          = v.rd;
        id_rd1         = v.rd1;
        id_rd2         = v.rd2;
        id_imm         = v.imm;
        id_alu_control = v.alu;
        id_alu_src_a   = v.sa;
        id_alu_src_b   = v.sb;
        id_reg_write   = v.rw;
        id_mem_read    = v.mr;
        id_mem_write   = v.mw;
        set_fwd(v.mrw, v.mrd, v.mres, v.wrw, v.wrd, v.wres);
        hold           = v.hold;
        flush          = v.flush;
    endtask

    initial begin
        // fields: iv pc rs1 rs2 rd rd1 rd2 imm alu sa sb rw mr mw | mem fwd | wb fwd | hold flush |
        //         exp SrcA SrcB store ALUControl valid rd reg_write mem_read mem_write stall
        vecs[0] = '{1'b1, 32'h0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
                    32'd5, 32'd7, 32'd7, 4'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h0, 5'd4, 5'd0, 5'd9, 32'h99, 32'h0, 32'h0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                    1'b1, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 1'b0,
                    32'h11, 32'h0, 32'h0, 4'd1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h4, 5'd6, 5'd0, 5'd10, 32'h77, 32'h0, 32'h0, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                    1'b0, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22, 1'b1, 1'b0,
                    32'h22, 32'h0, 32'h0, 4'd1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'h8, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'h0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                    1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 1'b0, 1'b0,
                    32'h0, 32'h0, 32'h0, 4'd7, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 32'h100, 5'd2, 5'd7, 5'd0, 32'h5, 32'h3, 32'h8, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                    1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
                    32'h100, 32'h8, 32'h55, 4'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 32'h104, 5'd3, 5'd8, 5'd4, 32'h10, 32'h20, 32'h40, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                    1'b1, 5'd9, 32'h1, 1'b1, 5'd8, 32'h333, 1'b0, 1'b0,
                    32'h10, 32'h333, 32'h333, 4'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 32'h108, 5'd0, 5'd5, 5'd2, 32'h0, 32'h50, 32'hFFFF_FFFC, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                    1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB, 1'b0, 1'b0,
                    32'h0, 32'hFFFF_FFFC, 32'hAA, 4'd0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 32'h200, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
                    32'h200, 32'h0, 32'h0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 32'h300, 5'd1, 5'd2, 5'd3, 32'h9, 32'h6, 32'h1, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                    1'b1, 5'd1, 32'h44, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1,
                    32'h0, 32'h0, 32'h0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset with live-looking inputs: outputs must sit at bubble values.
        rst_n = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h1234, 32'h5678, 1'b0, 1'b1, 1'b0);
        set_fwd(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
        repeat (2) @(posedge clk);
        #1;
        chk("rst ex_valid",      32'(ex_valid), 32'h0);
        chk("rst ALUControl",    32'(ALUControl), 32'h0);
        chk("rst ex_rd",         32'(ex_rd), 32'h0);
        chk("rst SrcA",          SrcA, 32'h0);
        chk("rst SrcB",          SrcB, 32'h0);
        chk("rst ex_store_data", ex_store_data, 32'h0);
        chk("rst stall_id",      32'(stall_id), 32'h0);
        chk("rst ex_reg_write",  32'(ex_reg_write), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d SrcA", i),          SrcA, vecs[i].e_srca);
            chk($sformatf("v%0d SrcB", i),          SrcB, vecs[i].e_srcb);
            chk($sformatf("v%0d ex_store_data", i), ex_store_data, vecs[i].e_store);
            chk($sformatf("v%0d ALUControl", i),    32'(ALUControl), 32'(vecs[i].e_alu));
            chk($sformatf("v%0d ex_valid", i),      32'(ex_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d ex_rd", i),         32'(ex_rd), 32'(vecs[i].e_rd));
            chk($sformatf("v%0d ex_reg_write", i),  32'(ex_reg_write), 32'(vecs[i].e_rw));
            chk($sformatf("v%0d ex_mem_read", i),   32'(ex_mem_read), 32'(vecs[i].e_mr));
            chk($sformatf("v%0d ex_mem_write", i),  32'(ex_mem_write), 32'(vecs[i].e_mw));
            chk($sformatf("v%0d stall_id", i),      32'(stall_id), 32'(vecs[i].e_stall));
        end

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID, with one held cycle first.
        @(negedge clk);
        hold = 1'b0;
        flush = 1'b0;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_id(1'b1, 5'd1, 5'd0, 5'd5, 32'h1000, 32'h0, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("lu lw ex_mem_read", 32'(ex_mem_read), 32'h1);
        chk("lu lw ex_rd",       32'(ex_rd), 32'd5);
        chk("lu lw no self stall", 32'(stall_id), 32'h0);
        @(negedge clk);
        set_id(1'b1, 5'd5, 5'd1, 5'd6, 32'h0, 32'h1000, 1'b0, 1'b1, 1'b0);
        hold = 1'b1;
        #1;
        chk("lu stall raised", 32'(stall_id), 32'h1);
        @(posedge clk);
        #1;
        chk("lu hold keeps mem_read", 32'(ex_mem_read), 32'h1);
        chk("lu hold keeps rd",       32'(ex_rd), 32'd5);
        chk("lu hold stall kept",     32'(stall_id), 32'h1);
        @(negedge clk);
        hold = 1'b0;
        set_fwd(1'b1, 5'd5, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("lu stall before bubble", 32'(stall_id), 32'h1);
        @(posedge clk);
        #1;
        chk("lu bubble ex_valid",    32'(ex_valid), 32'h0);
        chk("lu bubble ex_rd",       32'(ex_rd), 32'h0);
        chk("lu bubble reg_write",   32'(ex_reg_write), 32'h0);
        chk("lu stall one cycle",    32'(stall_id), 32'h0);
        @(negedge clk);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hCAFE);
        @(posedge clk);
        #1;
        chk("lu add ex_valid", 32'(ex_valid), 32'h1);
        chk("lu add ex_rd",    32'(ex_rd), 32'd6);
        chk("lu add SrcA wb",  SrcA, 32'hCAFE);
        chk("lu add SrcB",     SrcB, 32'h1000);
        chk("lu add stall",    32'(stall_id), 32'h0);

        // Flush with a load-use hazard and hold all asserted together.
        @(negedge clk);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_id(1'b1, 5'd1, 5'd0, 5'd5, 32'h1000, 32'h0, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_id(1'b1, 5'd5, 5'd1, 5'd6, 32'h0, 32'h1000, 1'b0, 1'b1, 1'b0);
        hold  = 1'b1;
        flush = 1'b1;
        #1;
        chk("fl stall masked", 32'(stall_id), 32'h0);
        @(posedge clk);
        #1;
        chk("fl ex_valid",     32'(ex_valid), 32'h0);
        chk("fl ex_reg_write", 32'(ex_reg_write), 32'h0);
        chk("fl ex_mem_read",  32'(ex_mem_read), 32'h0);

        // Hazard-shaped ID that is not valid must not stall.
        @(negedge clk);
        hold  = 1'b0;
        flush = 1'b0;
        set_id(1'b1, 5'd1, 5'd0, 5'd5, 32'h1000, 32'h0, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_id(1'b0, 5'd5, 5'd5, 5'd6, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("iv0 no stall", 32'(stall_id), 32'h0);

        // Asynchronous reset mid-operation, then a normal load on the first edge after release.
        @(negedge clk);
        set_id(1'b1, 5'd2, 5'd3, 5'd12, 32'h21, 32'h31, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("ar pre ex_rd", 32'(ex_rd), 32'd12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar ex_valid", 32'(ex_valid), 32'h0);
        chk("ar ex_rd",    32'(ex_rd), 32'h0);
        chk("ar SrcA",     SrcA, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        set_id(1'b1, 5'd2, 5'd3, 5'd7, 32'h21, 32'h31, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("ar post ex_valid", 32'(ex_valid), 32'h1);
        chk("ar post ex_rd",    32'(ex_rd), 32'd7);
        chk("ar post SrcA",     SrcA, 32'h21);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register plus operand forwarding and load-use hazard detection for the 5-stage RV32I core. Captures decoded instruction fields from ID, selects and forwards operands, and drives SrcA, SrcB and ALUControl straight into the ALU. It also raises the ID stall on load-use hazards and inserts bubbles on stall or flush.

## Interface
- No parameters; XLEN fixed at 32, register index width 5.
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  32  PC of ID instruction
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_rd1, id_rd2  in  32 each  register file read data (write-first file)
- id_imm  in  32  sign-extended immediate
- id_alu_control  in  4  ALU op code (package encoding)
- id_alu_src_a  in  1  0 = rs1, 1 = PC
- id_alu_src_b  in  1  0 = rs2, 1 = imm
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits
- mem_reg_write  in  1, mem_rd  in  5, mem_result  in  32  EX/MEM producer
- wb_reg_write  in  1, wb_rd  in  5, wb_result  in  32  MEM/WB producer
- hold  in  1  global freeze (memory busy)
- flush  in  1  branch/jump redirect; kill ID and EX contents
- SrcA, SrcB  out  32  ALU operands
- ALUControl  out  4  ALU op
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1 each
- ex_rd  out  5  destination index
- ex_store_data  out  32  forwarded rs2 value for stores
- stall_id  out  1  freeze PC and IF/ID this cycle

## Operation
- Register set: valid, pc, rs1, rs2, rd, rd1, rd2, imm, alu_control, alu_src_a/b, reg_write, mem_read, mem_write.
- Bubble: valid = 0, all control bits = 0, rd = rs1 = rs2 = 0, alu_control = ADD, data fields = 0.
- Next-state priority per edge: flush -> bubble; else hold -> keep; else stall_id -> bubble; else load from ID, with valid = id_valid.
- stall_id = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & (id_rs1 == ex_rd | id_rs2 == ex_rd) & ~flush. This is conservative: it compares rs2 even for I-type.
- Forward A (from registered rs1): MEM if mem_reg_write & mem_rd != 0 & mem_rd == rs1; else WB if wb_reg_write & wb_rd != 0 & wb_rd == rs1; else rd1. Forward B uses rs2 against rd2 the same way. MEM beats WB.
- SrcA = alu_src_a ? pc : fwdA. SrcB = alu_src_b ? imm : fwdB. ex_store_data = fwdB regardless of alu_src_b.
- ALUControl, ex_* outputs are direct register outputs. Forwarding uses the comparators only and must never depend on ex_valid. Bubbles carry rd = 0, so they never match.
- x0: a source index of 0 never forwards; rd1/rd2 are 0 from the file.

## Timing
- Reset (async, immediate): all registers at bubble values. ex_valid = 0, ALUControl = 4'b0000, ex_rd = 0, ex_store_data = 0, SrcA = SrcB = 0, stall_id = 0.
- ID-to-EX latency: 1 cycle. SrcA, SrcB and ex_store_data are combinational from registers and mem_/wb_ inputs in the same cycle.
- Load-use: stall_id is high for exactly 1 cycle per hazard. A bubble enters EX, and the consumer re-presents from ID the next cycle and then takes its operand from WB.
- hold and stall_id together: hold wins, the register keeps its contents and stall_id stays asserted. The upstream freezes either way.
- flush and any other condition together: bubble next cycle, stall_id = 0.
- Reset released mid-operation: first post-reset edge behaves as a normal load.

## Structure
- rv32i_pkg: ALU_ADD..ALU_AND 4-bit constants (ADD = 0 used for bubble), forward-select enum FWD_REG/FWD_MEM/FWD_WB, XLEN = 32.
- Sub-module forward_unit, combinational: inputs are the source index, mem/wb write enable and rd. The output is the 2-bit select. It is instantiated twice (A and B).

## Test plan
- Reset then load: id add x3,x1,x2 with rd1 = 5, rd2 = 7 -> next cycle SrcA = 5, SrcB = 7, ALUControl = 0, ex_rd = 3, ex_valid = 1.
- Double forward: EX rs1 = 4; MEM rd = 4 result 0x11; WB rd = 4 result 0x22 -> SrcA = 0x11. Drop mem_reg_write -> SrcA = 0x22.
- x0 guard: rs1 = 0, mem_rd = 0, mem_reg_write = 1, mem_result = 0xDEAD -> SrcA = 0.
- Load-use: EX lw x5, ID add x6,x5,x1 -> stall_id = 1 for one cycle, bubble (ex_valid = 0) in EX, then add in EX with SrcA = wb_result.
- Flush with hazard and hold all high -> next cycle ex_valid = 0, ex_reg_write = 0; stall_id = 0 while flush is high.
- Immediate/PC path with store: alu_src_a = 1, alu_src_b = 1, pc = 0x100, imm = 0x8, rs2 forwarded from MEM = 0x55 -> SrcA = 0x100, SrcB = 0x8, ex_store_data = 0x55.
